// File: rtl/spu_issue_scheduler_if.sv
// Instruction-pair and issue-control bundle between the IF_ID register and
// the SPU issue scheduler.
interface spu_issue_scheduler_if #(
   parameter int REG_W = 7,
   parameter int LAT_W = 3
);
   logic             flush;
   logic             i0_vld, i1_vld;
   logic [REG_W-1:0] i0_src_a, i0_src_b, i0_src_c;
   logic [REG_W-1:0] i1_src_a, i1_src_b, i1_src_c;
   logic [2:0]       i0_src_vld, i1_src_vld;
   logic [REG_W-1:0] i0_dst, i1_dst;
   logic             i0_dst_vld, i1_dst_vld;
   logic [LAT_W-1:0] i0_lat, i1_lat;
   logic             i0_pipe, i1_pipe;
   logic             issue0, issue1;
   logic             pc_enable;
   logic [15:0]      stall_cycles;

   modport master (
      output flush, i0_vld, i1_vld,
      output i0_src_a, i0_src_b, i0_src_c, i1_src_a, i1_src_b, i1_src_c,
      output i0_src_vld, i1_src_vld, i0_dst, i1_dst, i0_dst_vld, i1_dst_vld,
      output i0_lat, i1_lat, i0_pipe, i1_pipe,
      input  issue0, issue1, pc_enable, stall_cycles
   );

   modport slave (
      input  flush, i0_vld, i1_vld,
      input  i0_src_a, i0_src_b, i0_src_c, i1_src_a, i1_src_b, i1_src_c,
      input  i0_src_vld, i1_src_vld, i0_dst, i1_dst, i0_dst_vld, i1_dst_vld,
      input  i0_lat, i1_lat, i0_pipe, i1_pipe,
      output issue0, issue1, pc_enable, stall_cycles
   );
endinterface

// File: rtl/spu_issue_scheduler.sv
// In-order dual-issue scheduler for the SPU ID stage: latency-countdown
// register scoreboard, pair sequencing and fetch-stall control.
module spu_issue_scheduler #(
   parameter int NREG  = 128,
   parameter int LAT_W = 3
) (
   input logic                   clk,
   input logic                   reset,
   spu_issue_scheduler_if.slave  bus
);

   localparam int RW = $clog2(NREG);

   typedef enum logic {FULL = 1'b0, HALF = 1'b1} state_t;

   state_t           state, state_next;
   logic [LAT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  busy;
   logic             i0_ok, i1_ok, raw_pair, dst_clash, dual_ok;
   logic             pair_done, stall, load0, load1;
   logic [15:0]      stall_cnt;

   always_comb begin
      for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
   end

   // No bypass: every valid source and the destination (WAW) must be idle.
   always_comb begin
      i0_ok = !(bus.i0_src_vld[0] && busy[bus.i0_src_a]) &&
              !(bus.i0_src_vld[1] && busy[bus.i0_src_b]) &&
              !(bus.i0_src_vld[2] && busy[bus.i0_src_c]) &&
              !(bus.i0_dst_vld && busy[bus.i0_dst]);
      i1_ok = !(bus.i1_src_vld[0] && busy[bus.i1_src_a]) &&
              !(bus.i1_src_vld[1] && busy[bus.i1_src_b]) &&
              !(bus.i1_src_vld[2] && busy[bus.i1_src_c]) &&
              !(bus.i1_dst_vld && busy[bus.i1_dst]);
      raw_pair = bus.i0_dst_vld &&
                 ((bus.i1_src_vld[0] && (bus.i1_src_a == bus.i0_dst)) ||
                  (bus.i1_src_vld[1] && (bus.i1_src_b == bus.i0_dst)) ||
                  (bus.i1_src_vld[2] && (bus.i1_src_c == bus.i0_dst)));
      dst_clash = bus.i0_dst_vld && bus.i1_dst_vld && (bus.i0_dst == bus.i1_dst);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FULL;
      else        state <= state_next;
   end

   // NOTE: default assignment first so no path through this block infers a latch.
   always_comb begin
      state_next = state;
      if (bus.flush)
         state_next = FULL;
      else if ((state == FULL) && bus.issue0 && bus.i1_vld && !bus.issue1)
         state_next = HALF;
      else if ((state == HALF) && bus.issue1)
         state_next = FULL;
   end

   always_comb begin
      bus.issue0 = reset && !bus.flush && (state == FULL) && bus.i0_vld && i0_ok;
      dual_ok    = bus.issue0 && (bus.i0_pipe != bus.i1_pipe) && !raw_pair && !dst_clash;
      bus.issue1 = reset && !bus.flush && bus.i1_vld && i1_ok &&
                   ((state == HALF) || !bus.i0_vld || dual_ok);
      pair_done  = (!bus.i0_vld || bus.issue0 || (state == HALF)) &&
                   (!bus.i1_vld || bus.issue1);
      bus.pc_enable = reset && (bus.flush || pair_done || (!bus.i0_vld && !bus.i1_vld));
      stall = !bus.flush && !bus.issue0 && !bus.issue1 &&
              ((state == FULL) ? (bus.i0_vld || bus.i1_vld) : bus.i1_vld);
      load0 = bus.issue0 && bus.i0_dst_vld && (bus.i0_lat != '0);
      load1 = bus.issue1 && bus.i1_dst_vld && (bus.i1_lat != '0);
      bus.stall_cycles = stall_cnt;
   end

   // NOTE: the scoreboard array is reset because stale busy bits after reset
   // would block issue; flush deliberately leaves it running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (load0 && (bus.i0_dst == RW'(r)))      cnt[r] <= bus.i0_lat;
            else if (load1 && (bus.i1_dst == RW'(r))) cnt[r] <= bus.i1_lat;
            else if (busy[r])                          cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          stall_cnt <= '0;
      else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_spu_issue_scheduler.sv
// Self-checking bench for spu_issue_scheduler: a cycle table of pairs with
// hand-derived outputs, plus WAW, flush-in-HALF and reset-mid-stall sequences.
module tb_spu_issue_scheduler;

   typedef struct packed {
      logic       vld;
      logic [6:0] d;
      logic       dv;
      logic [2:0] lat;
      logic       pipe;
      logic [2:0] sv;
      logic [6:0] a, b, c;
   } slot_t;

   typedef struct {
      string      name;
      logic       fl;
      slot_t      s0, s1;
      logic [2:0] flags;   // {issue0, issue1, pc_enable}
      logic [15:0] stall;
   } vec_t;

   typedef struct {
      string       name;
      logic [2:0]  flags;
      logic [15:0] stall;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   int     checks = 0;
   int     errors = 0;
   vec_t   vecs[$];
   exp_t   exp_q[$];

   spu_issue_scheduler_if #(.REG_W(7), .LAT_W(3)) bus ();

   spu_issue_scheduler #(.NREG(128), .LAT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic slot_t mk(input logic vld, input logic [6:0] d, input logic dv,
                                input logic [2:0] lat, input logic pipe, input logic [2:0] sv,
                                input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
      slot_t s;
      s.vld = vld; s.d = d; s.dv = dv; s.lat = lat; s.pipe = pipe;
      s.sv = sv; s.a = a; s.b = b; s.c = c;
      return s;
   endfunction

   function automatic slot_t nop();
      return mk(1'b0, 7'd0, 1'b0, 3'd0, 1'b0, 3'b000, 7'd0, 7'd0, 7'd0);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input slot_t s0, input slot_t s1);
      bus.flush      = fl;
      bus.i0_vld     = s0.vld;  bus.i1_vld     = s1.vld;
      bus.i0_dst     = s0.d;    bus.i1_dst     = s1.d;
      bus.i0_dst_vld = s0.dv;   bus.i1_dst_vld = s1.dv;
      bus.i0_lat     = s0.lat;  bus.i1_lat     = s1.lat;
      bus.i0_pipe    = s0.pipe; bus.i1_pipe    = s1.pipe;
      bus.i0_src_vld = s0.sv;   bus.i1_src_vld = s1.sv;
      bus.i0_src_a   = s0.a;    bus.i1_src_a   = s1.a;
      bus.i0_src_b   = s0.b;    bus.i1_src_b   = s1.b;
      bus.i0_src_c   = s0.c;    bus.i1_src_c   = s1.c;
   endtask

   task automatic expect_out(input string name, input logic [2:0] flags, input logic [15:0] st);
      exp_t e;
      e.name = name; e.flags = flags; e.stall = st;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("queue_empty", 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         check({e.name, "/flags"}, {13'd0, bus.issue0, bus.issue1, bus.pc_enable}, {13'd0, e.flags});
         check({e.name, "/stall"}, bus.stall_cycles, e.stall);
      end
   endtask

   // One pipeline cycle: drive just after a rising edge, compare at the falling edge.
   task automatic step(input string name, input logic fl, input slot_t s0, input slot_t s1,
                       input logic [2:0] flags, input logic [15:0] st);
      drive(fl, s0, s1);
      expect_out(name, flags, st);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string name, input logic fl, input slot_t s0, input slot_t s1,
                      input logic [2:0] flags, input logic [15:0] st);
      vec_t v;
      v.name = name; v.fl = fl; v.s0 = s0; v.s1 = s1; v.flags = flags; v.stall = st;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      slot_t rd3, w4, rd4, w20, rd20, w22, rd22, w30, w31, w40a, w40b, rd40, w50, rd50;
      slot_t w7a, w7b, rd7, w60, rd60, w61, w70, rd70;

      rd3  = mk(1, 7'd10, 1, 3'd1, 0, 3'b001, 7'd3, 7'd0, 7'd0);
      w4   = mk(1, 7'd4, 1, 3'd2, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd4  = mk(1, 7'd0, 0, 3'd0, 0, 3'b001, 7'd4, 7'd0, 7'd0);
      w20  = mk(1, 7'd20, 1, 3'd0, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd20 = mk(1, 7'd21, 1, 3'd0, 1, 3'b001, 7'd20, 7'd0, 7'd0);
      w22  = mk(1, 7'd22, 1, 3'd2, 1, 3'b000, 7'd0, 7'd0, 7'd0);
      rd22 = mk(1, 7'd23, 0, 3'd0, 0, 3'b010, 7'd0, 7'd22, 7'd0);
      w30  = mk(1, 7'd30, 1, 3'd1, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      w31  = mk(1, 7'd31, 1, 3'd1, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      w40a = mk(1, 7'd40, 1, 3'd1, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      w40b = mk(1, 7'd40, 1, 3'd1, 1, 3'b000, 7'd0, 7'd0, 7'd0);
      rd40 = mk(1, 7'd41, 0, 3'd0, 0, 3'b001, 7'd40, 7'd0, 7'd0);
      w50  = mk(1, 7'd50, 1, 3'd3, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd50 = mk(1, 7'd51, 0, 3'd0, 0, 3'b001, 7'd50, 7'd0, 7'd0);

      add("dual_indep",    0, mk(1, 7'd3, 1, 3'd2, 0, 3'b011, 7'd1, 7'd2, 7'd0),
                               mk(1, 7'd4, 1, 3'd6, 1, 3'b001, 7'd1, 7'd0, 7'd0), 3'b111, 16'd0);
      add("raw_r3_wait1",  0, rd3, nop(), 3'b000, 16'd0);
      add("raw_r3_wait2",  0, rd3, nop(), 3'b000, 16'd1);
      add("raw_r3_issue",  0, rd3, nop(), 3'b101, 16'd2);
      add("waw_r4_wait1",  0, w4, nop(), 3'b000, 16'd2);
      add("waw_r4_wait2",  0, w4, nop(), 3'b000, 16'd3);
      add("waw_r4_wait3",  0, w4, nop(), 3'b000, 16'd4);
      add("waw_r4_issue",  0, w4, nop(), 3'b101, 16'd5);
      add("rd_r4_wait1",   0, rd4, nop(), 3'b000, 16'd5);
      add("rd_r4_wait2",   0, rd4, nop(), 3'b000, 16'd6);
      add("rd_r4_issue",   0, rd4, nop(), 3'b101, 16'd7);
      add("pair_raw0_c1",  0, w20, rd20, 3'b100, 16'd7);
      add("pair_raw0_c2",  0, w20, rd20, 3'b011, 16'd7);
      add("pair_raw2_c1",  0, w22, rd22, 3'b100, 16'd7);
      add("pair_raw2_w1",  0, w22, rd22, 3'b000, 16'd7);
      add("pair_raw2_w2",  0, w22, rd22, 3'b000, 16'd8);
      add("pair_raw2_c2",  0, w22, rd22, 3'b011, 16'd9);
      add("same_pipe_c1",  0, w30, w31, 3'b100, 16'd9);
      add("same_pipe_c2",  0, w30, w31, 3'b011, 16'd9);
      add("dst_clash_c1",  0, w40a, w40b, 3'b100, 16'd9);
      add("dst_clash_waw", 0, w40a, w40b, 3'b000, 16'd9);
      add("dst_clash_c2",  0, w40a, w40b, 3'b011, 16'd10);
      add("i1_alone_wait", 0, nop(), rd40, 3'b000, 16'd10);
      add("i1_alone_go",   0, nop(), rd40, 3'b011, 16'd11);
      add("both_empty",    0, nop(), nop(), 3'b001, 16'd11);
      add("flush_issue",   1, w50, nop(), 3'b001, 16'd11);
      add("flush_no_load", 0, rd50, nop(), 3'b101, 16'd11);

      reset = 1'b0;
      drive(1'b0, nop(), nop());
      #1;
      drive(1'b0, mk(1, 7'd3, 1, 3'd2, 0, 3'b000, 7'd0, 7'd0, 7'd0),
                  mk(1, 7'd4, 1, 3'd6, 1, 3'b000, 7'd0, 7'd0, 7'd0));
      expect_out("in_reset_valid", 3'b000, 16'd0);
      @(negedge clk);
      compare_out();
      drive(1'b0, nop(), nop());
      expect_out("in_reset_empty", 3'b000, 16'd0);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (vecs[i]) step(vecs[i].name, vecs[i].fl, vecs[i].s0, vecs[i].s1,
                             vecs[i].flags, vecs[i].stall);

      // WAW: r7 loaded with 3, second writer waits for it to drain, then reloads 5.
      w7a = mk(1, 7'd7, 1, 3'd3, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      w7b = mk(1, 7'd7, 1, 3'd5, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd7 = mk(1, 7'd8, 0, 3'd0, 0, 3'b100, 7'd0, 7'd0, 7'd7);
      step("waw7_load", 0, w7a, nop(), 3'b101, 16'd11);
      for (int k = 0; k < 3; k++) step("waw7_wait", 0, w7b, nop(), 3'b000, 16'(11 + k));
      step("waw7_issue", 0, w7b, nop(), 3'b101, 16'd14);
      for (int k = 0; k < 5; k++) step("waw7_rd_wait", 0, rd7, nop(), 3'b000, 16'(14 + k));
      step("waw7_rd_issue", 0, rd7, nop(), 3'b101, 16'd19);

      // Flush while HALF with i1 stalled; the next pair proves FULL and ongoing countdown.
      w60  = mk(1, 7'd60, 1, 3'd4, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd60 = mk(1, 7'd62, 0, 3'd0, 1, 3'b001, 7'd60, 7'd0, 7'd0);
      w61  = mk(1, 7'd61, 1, 3'd0, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      step("half_setup", 0, w60, rd60, 3'b100, 16'd19);
      step("half_flush", 1, w60, rd60, 3'b001, 16'd19);
      step("post_flush_full", 0, w61, rd60, 3'b100, 16'd19);
      step("post_flush_wait1", 0, w61, rd60, 3'b000, 16'd19);
      step("post_flush_wait2", 0, w61, rd60, 3'b000, 16'd20);
      step("post_flush_i1", 0, w61, rd60, 3'b011, 16'd21);

      // Reset dropped asynchronously in the middle of a stall.
      w70  = mk(1, 7'd70, 1, 3'd7, 0, 3'b000, 7'd0, 7'd0, 7'd0);
      rd70 = mk(1, 7'd71, 0, 3'd0, 0, 3'b001, 7'd70, 7'd0, 7'd0);
      step("rst_producer", 0, w70, nop(), 3'b101, 16'd21);
      step("rst_stall1", 0, rd70, nop(), 3'b000, 16'd21);
      step("rst_stall2", 0, rd70, nop(), 3'b000, 16'd22);
      drive(1'b0, rd70, nop());
      #2;
      reset = 1'b0;
      #1;
      expect_out("rst_async", 3'b000, 16'd0);
      compare_out();
      expect_out("rst_held", 3'b000, 16'd0);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
      reset = 1'b1;
      step("rst_release", 0, rd70, nop(), 3'b101, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
